hazard_control: RTL and testbench

Pipeline hazard unit and control-bundle carrier for the 5-stage MIPS pipeline. It consumes the decoded control bundle from the ID-stage control decoder and registers it through ID/EX, EX/MEM and MEM/WB. It detects load-use and control hazards and drives PC/IF-ID stall and flush. It produces forwarding selects for the EX-stage ALU muxes.

---
 rtl/pipeline_defs_pkg.sv | 64 ++++++
 rtl/forward_unit.sv | 22 ++
 rtl/hazard_control.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_control.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs_pkg.sv
// Shared pipeline definitions: control-bundle layout, forwarding selects,
// hazard FSM states and the opcode constants used by the ID-stage decoder.
package pipeline_defs;

    typedef struct packed {
        logic       branch_eq;
        logic       branch_ne;
        logic       memory_read;
        logic       memory_write;
        logic       memory_to_register;
        logic       register_destination;
        logic       register_write;
        logic       alu_source;
        logic       jump;
        logic [1:0] alu_opcode;
    } ctrl_t;

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
    } id_ex_t;

    typedef struct packed {
        logic             register_write;
        logic             memory_read;
        logic             memory_write;
        logic             memory_to_register;
        logic [REG_W-1:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic             register_write;
        logic             memory_to_register;
        logic [REG_W-1:0] dest;
    } mem_wb_t;

    localparam logic [1:0] FORWARD_RF    = 2'b00;
    localparam logic [1:0] FORWARD_EXMEM = 2'b10;
    localparam logic [1:0] FORWARD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } hz_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // rt is a source for R-type ALU ops, stores and branches.
    function automatic logic uses_rt(ctrl_t c);
        return ~c.alu_source | c.memory_write | c.branch_eq | c.branch_ne;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one ALU operand; EX/MEM has priority over MEM/WB.
module forward_unit
    import pipeline_defs::*;
(
    input  logic [4:0] src,
    input  logic       mem_register_write,
    input  logic [4:0] mem_dest,
    input  logic       wb_register_write,
    input  logic [4:0] wb_dest,
    output logic [1:0] forward
);

    always_comb begin
        forward = FORWARD_RF;
        if (mem_register_write && (mem_dest != 5'd0) && (mem_dest == src)) begin
            forward = FORWARD_EXMEM;
        end else if (wb_register_write && (wb_dest != 5'd0) && (wb_dest == src)) begin
            forward = FORWARD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Hazard unit for the 5-stage pipeline: carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, resolves stalls/flushes and drives forwarding.
module hazard_control
    import pipeline_defs::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_branch_eq,
    input  logic             id_branch_ne,
    input  logic             id_memory_read,
    input  logic             id_memory_write,
    input  logic             id_memory_to_register,
    input  logic             id_register_destination,
    input  logic             id_register_write,
    input  logic             id_alu_source,
    input  logic             id_jump,
    input  logic [1:0]       id_alu_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_alu_zero,

    output logic             ex_branch_eq,
    output logic             ex_branch_ne,
    output logic             ex_memory_read,
    output logic             ex_memory_write,
    output logic             ex_memory_to_register,
    output logic             ex_register_destination,
    output logic             ex_register_write,
    output logic             ex_alu_source,
    output logic             ex_jump,
    output logic [1:0]       ex_alu_opcode,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,

    output logic             mem_register_write,
    output logic             mem_memory_read,
    output logic             mem_memory_write,
    output logic             mem_memory_to_register,
    output logic [4:0]       mem_dest,

    output logic             wb_register_write,
    output logic             wb_memory_to_register,
    output logic [4:0]       wb_dest,

    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             branch_taken,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    id_ex_t             id_ex_q, id_ex_d;
    ex_mem_t            ex_mem_q, ex_mem_d;
    mem_wb_t            mem_wb_q, mem_wb_d;
    hz_state_e          state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    ctrl_t id_ctrl;
    logic  load_use;
    logic  stall;
    logic  bubble;

    assign id_ctrl = '{
        branch_eq:            id_branch_eq,
        branch_ne:            id_branch_ne,
        memory_read:          id_memory_read,
        memory_write:         id_memory_write,
        memory_to_register:   id_memory_to_register,
        register_destination: id_register_destination,
        register_write:       id_register_write,
        alu_source:           id_alu_source,
        jump:                 id_jump,
        alu_opcode:           id_alu_opcode
    };

    always_comb begin
        branch_taken = (id_ex_q.ctrl.branch_eq & ex_alu_zero) |
                       (id_ex_q.ctrl.branch_ne & ~ex_alu_zero);
        load_use     = id_ex_q.ctrl.memory_read && (id_ex_q.dest != 5'd0) &&
                       ((id_ex_q.dest == id_rs) || (uses_rt(id_ctrl) && (id_ex_q.dest == id_rt)));
        // The bubble behind a stall clears memory_read in EX, so a repeat stall
        // is unreachable; gating on StStall keeps the FSM from ever holding there.
        stall        = load_use & ~branch_taken & (state_q != StStall);
        bubble       = branch_taken | stall;

        pc_write     = ~stall;
        if_id_write  = ~stall;
        if_id_flush  = branch_taken | (id_jump & ~stall);
    end

    always_comb begin
        id_ex_d = '0;
        if (!bubble) begin
            id_ex_d.ctrl = id_ctrl;
            id_ex_d.rs   = id_rs;
            id_ex_d.rt   = id_rt;
            id_ex_d.dest = id_register_destination ? id_rd : id_rt;
        end

        ex_mem_d = '{
            register_write:     id_ex_q.ctrl.register_write,
            memory_read:        id_ex_q.ctrl.memory_read,
            memory_write:       id_ex_q.ctrl.memory_write,
            memory_to_register: id_ex_q.ctrl.memory_to_register,
            dest:               id_ex_q.dest
        };

        mem_wb_d = '{
            register_write:     ex_mem_q.register_write,
            memory_to_register: ex_mem_q.memory_to_register,
            dest:               ex_mem_q.dest
        };
    end

    always_comb begin
        state_d = StRun;
        if (if_id_flush) begin
            state_d = StFlush;
        end else if (stall) begin
            state_d = StStall;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q     <= '0;
            ex_mem_q    <= '0;
            mem_wb_q    <= '0;
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            ex_mem_q    <= ex_mem_d;
            mem_wb_q    <= mem_wb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    forward_unit u_forward_a (
        .src                (id_ex_q.rs),
        .mem_register_write (ex_mem_q.register_write),
        .mem_dest           (ex_mem_q.dest),
        .wb_register_write  (mem_wb_q.register_write),
        .wb_dest            (mem_wb_q.dest),
        .forward            (forward_a)
    );

    forward_unit u_forward_b (
        .src                (id_ex_q.rt),
        .mem_register_write (ex_mem_q.register_write),
        .mem_dest           (ex_mem_q.dest),
        .wb_register_write  (mem_wb_q.register_write),
        .wb_dest            (mem_wb_q.dest),
        .forward            (forward_b)
    );

    assign ex_branch_eq            = id_ex_q.ctrl.branch_eq;
    assign ex_branch_ne            = id_ex_q.ctrl.branch_ne;
    assign ex_memory_read          = id_ex_q.ctrl.memory_read;
    assign ex_memory_write         = id_ex_q.ctrl.memory_write;
    assign ex_memory_to_register   = id_ex_q.ctrl.memory_to_register;
    assign ex_register_destination = id_ex_q.ctrl.register_destination;
    assign ex_register_write       = id_ex_q.ctrl.register_write;
    assign ex_alu_source           = id_ex_q.ctrl.alu_source;
    assign ex_jump                 = id_ex_q.ctrl.jump;
    assign ex_alu_opcode           = id_ex_q.ctrl.alu_opcode;
    assign ex_rs                   = id_ex_q.rs;
    assign ex_rt                   = id_ex_q.rt;
    assign ex_dest                 = id_ex_q.dest;

    assign mem_register_write      = ex_mem_q.register_write;
    assign mem_memory_read         = ex_mem_q.memory_read;
    assign mem_memory_write        = ex_mem_q.memory_write;
    assign mem_memory_to_register  = ex_mem_q.memory_to_register;
    assign mem_dest                = ex_mem_q.dest;

    assign wb_register_write       = mem_wb_q.register_write;
    assign wb_memory_to_register   = mem_wb_q.memory_to_register;
    assign wb_dest                 = mem_wb_q.dest;

    assign stall_count             = stall_cnt_q;
    assign flush_count             = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: an instruction-level pipeline model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_hazard_control;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic beq, bne, mr, mw, m2r, rdst, rw, asrc, j;
        logic [1:0] aop;
        logic [4:0] rs, rt, rd;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ex_alu_zero = 1'b0;
    instr_t cur = '0;

    logic ex_branch_eq, ex_branch_ne, ex_memory_read, ex_memory_write;
    logic ex_memory_to_register, ex_register_destination, ex_register_write;
    logic ex_alu_source, ex_jump;
    logic [1:0] ex_alu_opcode;
    logic [4:0] ex_rs, ex_rt, ex_dest;
    logic mem_register_write, mem_memory_read, mem_memory_write, mem_memory_to_register;
    logic [4:0] mem_dest;
    logic wb_register_write, wb_memory_to_register;
    logic [4:0] wb_dest;
    logic pc_write, if_id_write, if_id_flush, branch_taken;
    logic [1:0] forward_a, forward_b;
    logic [CNT_W-1:0] stall_count, flush_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_control #(.CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .id_branch_eq            (cur.beq),
        .id_branch_ne            (cur.bne),
        .id_memory_read          (cur.mr),
        .id_memory_write         (cur.mw),
        .id_memory_to_register   (cur.m2r),
        .id_register_destination (cur.rdst),
        .id_register_write       (cur.rw),
        .id_alu_source           (cur.asrc),
        .id_jump                 (cur.j),
        .id_alu_opcode           (cur.aop),
        .id_rs                   (cur.rs),
        .id_rt                   (cur.rt),
        .id_rd                   (cur.rd),
        .ex_alu_zero             (ex_alu_zero),
        .ex_branch_eq            (ex_branch_eq),
        .ex_branch_ne            (ex_branch_ne),
        .ex_memory_read          (ex_memory_read),
        .ex_memory_write         (ex_memory_write),
        .ex_memory_to_register   (ex_memory_to_register),
        .ex_register_destination (ex_register_destination),
        .ex_register_write       (ex_register_write),
        .ex_alu_source           (ex_alu_source),
        .ex_jump                 (ex_jump),
        .ex_alu_opcode           (ex_alu_opcode),
        .ex_rs                   (ex_rs),
        .ex_rt                   (ex_rt),
        .ex_dest                 (ex_dest),
        .mem_register_write      (mem_register_write),
        .mem_memory_read         (mem_memory_read),
        .mem_memory_write        (mem_memory_write),
        .mem_memory_to_register  (mem_memory_to_register),
        .mem_dest                (mem_dest),
        .wb_register_write       (wb_register_write),
        .wb_memory_to_register   (wb_memory_to_register),
        .wb_dest                 (wb_dest),
        .pc_write                (pc_write),
        .if_id_write             (if_id_write),
        .if_id_flush             (if_id_flush),
        .branch_taken            (branch_taken),
        .forward_a               (forward_a),
        .forward_b               (forward_b),
        .stall_count             (stall_count),
        .flush_count             (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction builders in decoder terms.
    function automatic instr_t mk_add(input logic [4:0] rs, rt, rd);
        instr_t i = '0;
        i.rdst = 1'b1; i.rw = 1'b1; i.aop = 2'b10;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rs, rt);
        instr_t i = '0;
        i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.asrc = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t mk_sw(input logic [4:0] rs, rt);
        instr_t i = '0;
        i.mw = 1'b1; i.asrc = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t mk_br(input logic ne, input logic [4:0] rs, rt);
        instr_t i = '0;
        i.beq = ~ne; i.bne = ne; i.aop = 2'b01;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t mk_j();
        instr_t i = '0;
        i.j = 1'b1;
        return i;
    endfunction

    // ---------------- behavioural model ----------------
    instr_t m_ex = '0, m_mem = '0, m_wb = '0;
    int     m_stalls = 0, m_flushes = 0;
    localparam int CMAX = (1 << CNT_W) - 1;

    function automatic logic [4:0] dest_of(input instr_t i);
        return i.rdst ? i.rd : i.rt;
    endfunction

    function automatic logic reads_rt(input instr_t i);
        return !i.asrc || i.mw || i.beq || i.bne;
    endfunction

    function automatic logic m_branch();
        return (m_ex.beq && ex_alu_zero) || (m_ex.bne && !ex_alu_zero);
    endfunction

    function automatic logic m_load_use();
        logic [4:0] d = dest_of(m_ex);
        if (!m_ex.mr || d == 5'd0) return 1'b0;
        return (d == cur.rs) || (reads_rt(cur) && d == cur.rt);
    endfunction

    // Nearest older writer of the source register wins.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (m_mem.rw && dest_of(m_mem) == src) return 2'b10;
        if (m_wb.rw && dest_of(m_wb) == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            logic br, st, fl;
            br = m_branch();
            st = m_load_use() && !br;
            fl = br || (cur.j && !st);
            if (st && m_stalls < CMAX) m_stalls++;
            if (fl && m_flushes < CMAX) m_flushes++;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (br || st) ? instr_t'('0) : cur;
        end
    end

    always @(negedge clk) begin
        logic br, st;
        br = m_branch();
        st = m_load_use() && !br;
        chk("ex_ctrl", {ex_branch_eq, ex_branch_ne, ex_memory_read, ex_memory_write,
                        ex_memory_to_register, ex_register_destination, ex_register_write,
                        ex_alu_source, ex_jump, ex_alu_opcode},
            {m_ex.beq, m_ex.bne, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.rdst, m_ex.rw,
             m_ex.asrc, m_ex.j, m_ex.aop});
        chk("ex_regs", {ex_rs, ex_rt, ex_dest}, {m_ex.rs, m_ex.rt, dest_of(m_ex)});
        chk("mem_bundle", {mem_register_write, mem_memory_read, mem_memory_write,
                           mem_memory_to_register, mem_dest},
            {m_mem.rw, m_mem.mr, m_mem.mw, m_mem.m2r, dest_of(m_mem)});
        chk("wb_bundle", {wb_register_write, wb_memory_to_register, wb_dest},
            {m_wb.rw, m_wb.m2r, dest_of(m_wb)});
        chk("pc_write", pc_write, !st);
        chk("if_id_write", if_id_write, !st);
        chk("if_id_flush", if_id_flush, br || (cur.j && !st));
        chk("branch_taken", branch_taken, br);
        chk("forward_a", forward_a, m_fwd(m_ex.rs));
        chk("forward_b", forward_b, m_fwd(m_ex.rt));
        chk("stall_count", stall_count, m_stalls);
        chk("flush_count", flush_count, m_flushes);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        instr_t odd;
        repeat (3) tick();
        chk("rst_pc_write", pc_write, 1'b1);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_ex_rw", ex_register_write, 1'b0);
        rst_n = 1'b1;
        tick();

        // Load-use: lw $2 then add using $2.
        cur = mk_lw(5'd1, 5'd2); tick();
        cur = mk_add(5'd2, 5'd3, 5'd4); #1;
        chk("lu_pc_write", pc_write, 1'b0);
        chk("lu_if_id_write", if_id_write, 1'b0);
        tick();
        chk("lu_bubble_rw", ex_register_write, 1'b0);
        chk("lu_stall_count", stall_count, 1);
        tick();
        chk("lu_fwd_memwb", forward_a, 2'b01);

        // EX/MEM beats MEM/WB; then only MEM/WB writes $5.
        cur = mk_add(5'd1, 5'd1, 5'd5); tick();
        cur = mk_add(5'd1, 5'd1, 5'd5); tick();
        cur = mk_add(5'd5, 5'd0, 5'd6); tick();
        chk("fwd_exmem", forward_a, 2'b10);
        chk("fwd_b_rf", forward_b, 2'b00);
        cur = mk_add(5'd1, 5'd1, 5'd5); tick();
        cur = mk_sw(5'd1, 5'd5); tick();
        cur = mk_add(5'd5, 5'd0, 5'd6); tick();
        chk("fwd_memwb", forward_a, 2'b01);

        // Register 0 never forwards and never stalls.
        cur = mk_add(5'd1, 5'd1, 5'd0); tick();
        cur = mk_add(5'd0, 5'd0, 5'd7); tick();
        chk("r0_fwd_a", forward_a, 2'b00);
        cur = mk_lw(5'd1, 5'd0); tick();
        cur = mk_add(5'd0, 5'd0, 5'd8); #1;
        chk("r0_no_stall", pc_write, 1'b1);
        tick();
        chk("r0_stall_count", stall_count, 1);

        // Taken bne coinciding with load-use: flush wins.
        odd = mk_br(1'b1, 5'd1, 5'd7);
        odd.mr = 1'b1;
        cur = odd; tick();
        ex_alu_zero = 1'b0;
        cur = mk_add(5'd7, 5'd7, 5'd9); #1;
        chk("bl_branch_taken", branch_taken, 1'b1);
        chk("bl_flush", if_id_flush, 1'b1);
        chk("bl_pc_write", pc_write, 1'b1);
        tick();
        chk("bl_stall_count", stall_count, 1);
        chk("bl_flush_count", flush_count, 1);
        chk("bl_bubble", ex_register_write, 1'b0);

        // Taken beq.
        cur = mk_br(1'b0, 5'd3, 5'd3); tick();
        ex_alu_zero = 1'b1; #1;
        chk("beq_taken", branch_taken, 1'b1);
        tick();
        ex_alu_zero = 1'b0;
        chk("beq_flush_count", flush_count, 2);

        // Jump proceeds into EX while IF/ID is flushed.
        cur = mk_j(); #1;
        chk("j_flush", if_id_flush, 1'b1);
        tick();
        cur = '0;
        chk("j_ex_jump", ex_jump, 1'b1);
        chk("j_flush_count", flush_count, 3);
        tick();

        // Flush held long enough to saturate the counter.
        cur = mk_j();
        repeat ((1 << CNT_W) + 3) tick();
        chk("sat_flush_count", flush_count, 15);
        cur = '0; tick();
        chk("sat_hold", flush_count, 15);

        // Reset asserted mid-stall releases it immediately.
        cur = mk_lw(5'd1, 5'd4); tick();
        cur = mk_add(5'd4, 5'd0, 5'd1); #1;
        chk("mid_stall", pc_write, 1'b0);
        rst_n = 1'b0; #1;
        chk("mid_rst_pc_write", pc_write, 1'b1);
        chk("mid_rst_ex_mr", ex_memory_read, 1'b0);
        chk("mid_rst_stall_count", stall_count, 0);
        chk("mid_rst_flush_count", flush_count, 0);
        tick();
        cur = '0;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
